instr_decode_ctrl: RTL and testbench

//   Downstream neighbour of the program counter stage. Consumes the instruction word

---
 rtl/instr_decode_ctrl.sv | 137 +++++++++++++
 tb/tb_instr_decode_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/instr_decode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : instr_decode_ctrl
// Brief    : Instruction decode and per-program run control (Start/HALT/Ack),
//            with halt-PC capture and a saturating executed-cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
module instr_decode_ctrl #(
   parameter int IW   = 9,
   parameter int PCW  = 11,
   parameter int CNTW = 16
) (
   input  logic            Clk,
   input  logic            Reset,
   input  logic            Start,
   input  logic [IW-1:0]   Instr,
   input  logic [PCW-1:0]  ProgCtr,
   output logic            BranchEn,
   output logic [7:0]      Target,
   output logic [2:0]      AluOp,
   output logic [3:0]      RegAddr,
   output logic            RegWrEn,
   output logic            MemRdEn,
   output logic            MemWrEn,
   output logic            Ack,
   output logic [PCW-1:0]  HaltPc,
   output logic [CNTW-1:0] CycleCount
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [2:0] C_OP_LD   = 3'b100;
   localparam logic [2:0] C_OP_ST   = 3'b101;
   localparam logic [2:0] C_OP_BR   = 3'b110;
   localparam logic [2:0] C_OP_SYS  = 3'b111;
   localparam logic [5:0] C_IMM_HLT = 6'h3F;

   state_t          r_state;
   state_t          w_state_nxt;
   logic            r_ack;
   logic [PCW-1:0]  r_halt_pc;
   logic [CNTW-1:0] r_cycle_cnt;

   logic            w_exec;
   logic            w_halt;
   logic            w_enter_run;
   logic [2:0]      w_op;
   logic [5:0]      w_imm;
   logic [3:0]      w_reg;

   assign w_op  = Instr[8:6];
   assign w_imm = Instr[5:0];
   assign w_reg = Instr[3:0];

   // Reset blanks decode immediately rather than waiting for the state to clear.
   assign w_exec      = (r_state == S_RUN) && !Start && !Reset;
   assign w_halt      = w_exec && (w_op == C_OP_SYS) && (w_imm == C_IMM_HLT);
   assign w_enter_run = (r_state != S_RUN) && (w_state_nxt == S_RUN);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (Start)  w_state_nxt = S_RUN;
         S_RUN:   if (w_halt) w_state_nxt = S_DONE;
         S_DONE:  if (Start)  w_state_nxt = S_RUN;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      BranchEn = 1'b0;
      Target   = 8'd0;
      AluOp    = 3'd0;
      RegAddr  = 4'd0;
      RegWrEn  = 1'b0;
      MemRdEn  = 1'b0;
      MemWrEn  = 1'b0;
      if (w_exec) begin
         case (w_op)
            C_OP_LD: begin
               MemRdEn = 1'b1;
               RegWrEn = 1'b1;
               RegAddr = w_reg;
            end
            C_OP_ST: begin
               MemWrEn = 1'b1;
               RegAddr = w_reg;
            end
            C_OP_BR: begin
               BranchEn = 1'b1;
               Target   = {{2{w_imm[5]}}, w_imm};
            end
            C_OP_SYS: ;
            default: begin
               AluOp   = w_op;
               RegAddr = w_reg;
               RegWrEn = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state     <= S_IDLE;
         r_ack       <= 1'b0;
         r_halt_pc   <= '0;
         r_cycle_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;

         if (w_halt) begin
            r_ack     <= 1'b1;
            r_halt_pc <= ProgCtr;
         end else if ((r_state == S_DONE) && Start) begin
            r_ack <= 1'b0;
         end

         // A fresh program always starts counting from zero; the HALT cycle counts.
         if (w_enter_run) begin
            r_cycle_cnt <= '0;
         end else if (w_exec && (r_cycle_cnt != {CNTW{1'b1}})) begin
            r_cycle_cnt <= r_cycle_cnt + 1'b1;
         end
      end
   end

   assign Ack        = r_ack;
   assign HaltPc     = r_halt_pc;
   assign CycleCount = r_cycle_cnt;

endmodule
`default_nettype wire

// File: tb/tb_instr_decode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_decode_ctrl
// Brief    : Directed plus randomized checks of instr_decode_ctrl against a
//            behavioural model (full-width and narrow-counter instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_decode_ctrl;

   localparam int C_SW = 5;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        Start;
   logic [8:0]  Instr;
   logic [10:0] ProgCtr;

   logic        BranchEn, RegWrEn, MemRdEn, MemWrEn, Ack;
   logic [7:0]  Target;
   logic [2:0]  AluOp;
   logic [3:0]  RegAddr;
   logic [10:0] HaltPc;
   logic [15:0] CycleCount;

   logic        s_BranchEn, s_RegWrEn, s_MemRdEn, s_MemWrEn, s_Ack;
   logic [7:0]  s_Target;
   logic [2:0]  s_AluOp;
   logic [3:0]  s_RegAddr;
   logic [10:0] s_HaltPc;
   logic [C_SW-1:0] s_CycleCount;

   int n_assert = 0;
   int n_fail   = 0;

   // model: mode 0=idle 1=running 2=finished
   int          m_mode;
   bit          m_ack;
   logic [10:0] m_hpc;
   longint      m_execs;

   always #5 Clk = ~Clk;

   instr_decode_ctrl #(.IW(9), .PCW(11), .CNTW(16)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Instr(Instr), .ProgCtr(ProgCtr),
      .BranchEn(BranchEn), .Target(Target), .AluOp(AluOp), .RegAddr(RegAddr),
      .RegWrEn(RegWrEn), .MemRdEn(MemRdEn), .MemWrEn(MemWrEn), .Ack(Ack),
      .HaltPc(HaltPc), .CycleCount(CycleCount)
   );

   instr_decode_ctrl #(.IW(9), .PCW(11), .CNTW(C_SW)) dut_sat (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Instr(Instr), .ProgCtr(ProgCtr),
      .BranchEn(s_BranchEn), .Target(s_Target), .AluOp(s_AluOp), .RegAddr(s_RegAddr),
      .RegWrEn(s_RegWrEn), .MemRdEn(s_MemRdEn), .MemWrEn(s_MemWrEn), .Ack(s_Ack),
      .HaltPc(s_HaltPc), .CycleCount(s_CycleCount)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic longint sat(input longint v, input int w);
      longint mx = (longint'(1) << w) - 1;
      return (v > mx) ? mx : v;
   endfunction

   // One clock: check decode mid-cycle, advance model at the edge, check registers.
   task automatic tick();
      bit         e_br, e_wr, e_rd, e_st, ex, hlt;
      logic [7:0] e_tgt;
      logic [2:0] e_alu;
      logic [3:0] e_reg;
      int         op, imm;
      #1;
      op  = int'(Instr[8:6]);
      imm = int'(Instr[5:0]);
      ex  = (m_mode == 1) && !Start && !Reset;
      hlt = ex && (op == 7) && (imm == 63);
      e_br = 0; e_wr = 0; e_rd = 0; e_st = 0; e_tgt = 0; e_alu = 0; e_reg = 0;
      if (ex) begin
         if (op <= 3) begin
            e_alu = 3'(op); e_reg = Instr[3:0]; e_wr = 1;
         end else if (op == 4) begin
            e_rd = 1; e_wr = 1; e_reg = Instr[3:0];
         end else if (op == 5) begin
            e_st = 1; e_reg = Instr[3:0];
         end else if (op == 6) begin
            e_br  = 1;
            e_tgt = 8'((imm >= 32) ? imm - 64 : imm);
         end
      end
      chk("BranchEn", 32'(BranchEn), 32'(e_br));
      chk("Target",   32'(Target),   32'(e_tgt));
      chk("AluOp",    32'(AluOp),    32'(e_alu));
      chk("RegAddr",  32'(RegAddr),  32'(e_reg));
      chk("RegWrEn",  32'(RegWrEn),  32'(e_wr));
      chk("MemRdEn",  32'(MemRdEn),  32'(e_rd));
      chk("MemWrEn",  32'(MemWrEn),  32'(e_st));
      chk("s_decode", {s_BranchEn, s_Target, s_AluOp, s_RegAddr, s_RegWrEn, s_MemRdEn, s_MemWrEn},
                      {e_br, e_tgt, e_alu, e_reg, e_wr, e_rd, e_st});

      @(posedge Clk);
      if (Reset) begin
         m_mode = 0; m_ack = 0; m_hpc = 0; m_execs = 0;
      end else if (m_mode != 1) begin
         if (Start) begin
            m_mode = 1; m_ack = 0; m_execs = 0;
         end
      end else begin
         if (ex) m_execs++;
         if (hlt) begin
            m_mode = 2; m_ack = 1; m_hpc = ProgCtr;
         end
      end
      #1;
      chk("Ack",          32'(Ack),          32'(m_ack));
      chk("HaltPc",       32'(HaltPc),       32'(m_hpc));
      chk("CycleCount",   32'(CycleCount),   32'(sat(m_execs, 16)));
      chk("s_Ack",        32'(s_Ack),        32'(m_ack));
      chk("s_HaltPc",     32'(s_HaltPc),     32'(m_hpc));
      chk("s_CycleCount", 32'(s_CycleCount), 32'(sat(m_execs, C_SW)));
   endtask

   initial begin
      m_mode = 0; m_ack = 0; m_hpc = 0; m_execs = 0;
      Reset = 1; Start = 1; Instr = 9'b001_00_0101; ProgCtr = 0;

      // Reset with Start held high
      tick(); tick();
      chk("rst_count", 32'(CycleCount), 32'd0);

      // Start pulse then SUB r5
      Reset = 0; Start = 1; tick();
      Start = 0; Instr = 9'b001_00_0101; ProgCtr = 0;
      #1;
      chk("sub_alu", 32'(AluOp), 32'd1);
      chk("sub_reg", 32'(RegAddr), 32'd5);
      tick();
      chk("sub_count", 32'(CycleCount), 32'd1);

      // Four more ALU ops, then HALT at PC 6
      for (int i = 1; i < 5; i++) begin
         Instr = {3'(i % 4), 2'b00, 4'(i + 2)}; ProgCtr = 11'(i); tick();
      end
      Instr = 9'h1FF; ProgCtr = 11'd6; tick();
      chk("halt_ack", 32'(Ack), 32'd1);
      chk("halt_pc", 32'(HaltPc), 32'd6);
      chk("halt_count", 32'(CycleCount), 32'd6);
      Instr = 9'b000_00_0011; ProgCtr = 11'd7; tick(); tick();

      // Restart from DONE, branches, LD/ST, HALT under Start ignored
      Start = 1; tick();
      chk("restart_ack", 32'(Ack), 32'd0);
      chk("restart_count", 32'(CycleCount), 32'd0);
      Start = 0; Instr = 9'b110_111110; tick();
      Instr = 9'b110_000011; tick();
      Instr = 9'b100_00_1001; tick();
      Instr = 9'b101_00_1100; tick();
      Instr = 9'b111_000101; tick();
      Start = 1; Instr = 9'h1FF; ProgCtr = 11'd42; tick();
      chk("halt_stalled_ack", 32'(Ack), 32'd0);
      Start = 0; Instr = 9'b010_00_0001; tick(); tick(); tick();

      // Reset mid-run
      Reset = 1; tick();
      chk("midrst_count", 32'(CycleCount), 32'd0);
      Reset = 0; Start = 0; tick();

      // Saturation: narrow instance pins at its max, wide one keeps counting
      Reset = 1; Start = 1; tick();
      Reset = 0; tick();
      Start = 0; Instr = 9'b011_00_0010;
      for (int i = 0; i < 40; i++) tick();
      chk("sat_narrow", 32'(s_CycleCount), 32'd31);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         Reset   = ($urandom_range(0, 29) == 0);
         Start   = ($urandom_range(0, 7) == 0);
         Instr   = ($urandom_range(0, 5) == 0) ? 9'h1FF : 9'($urandom);
         ProgCtr = 11'($urandom);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
